tmu2_blend_arb: RTL and testbench

- Round-robin arbiter that shares one tmu2_blend bilinear-blend pipeline between two texel requesters (e.g. two tmu2 fetch/filter lanes).
- Issues each granted request into the blend pipeline and records its requester ID in an in-order tag FIFO.
- Steers each blend result back to the requester that issued it.
- Sits between the texel cache/fetch stages and tmu2_blend. On the result side it feeds the per-lane pixel writers.

---
 rtl/tmu2_blend_arb_pkg.sv | 26 ++
 rtl/tmu2_tagfifo.sv | 51 +++++
 rtl/tmu2_blend_arb.sv | 91 +++++++++
 tb/tb_tmu2_blend_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmu2_blend_arb_pkg.sv
// Shared bundle layout and sizing helpers for the tmu2 blend arbiter slice.
// Bundle is {dadr, colora, colorb, colorc, colord, x_frac, y_frac}, dadr in the MSBs.
package tmu2_blend_arb_pkg;

  localparam int unsigned REQ_N     = 2;
  localparam int unsigned COLOR_W   = 16;
  localparam int unsigned FRAC_W    = 6;

  localparam int unsigned YFRAC_OFF  = 0;
  localparam int unsigned XFRAC_OFF  = YFRAC_OFF + FRAC_W;
  localparam int unsigned COLORD_OFF = XFRAC_OFF + FRAC_W;
  localparam int unsigned COLORC_OFF = COLORD_OFF + COLOR_W;
  localparam int unsigned COLORB_OFF = COLORC_OFF + COLOR_W;
  localparam int unsigned COLORA_OFF = COLORB_OFF + COLOR_W;
  localparam int unsigned DADR_OFF   = COLORA_OFF + COLOR_W;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  function automatic int unsigned BUNDLE_W(input int unsigned fml_depth);
    return fml_depth - 1 + DADR_OFF;
  endfunction

endpackage

// File: rtl/tmu2_tagfifo.sv
// In-order requester-ID FIFO for blend operations in flight.
// Push while empty is not bypassed; head is valid one cycle after the push.
module tmu2_tagfifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_push_tag,
  input  logic                     i_pop,
  output logic                     o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // A pop frees the slot this cycle, so push-while-full is legal alongside it.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_tag;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

endmodule

// File: rtl/tmu2_blend_arb.sv
// Round-robin share of one tmu2_blend pipeline between two texel lanes;
// results are steered back by an in-order tag FIFO with zero added latency.
module tmu2_blend_arb
  import tmu2_blend_arb_pkg::*;
#(
  parameter int unsigned fml_depth = 26,
  parameter int unsigned tag_depth = 8
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  output logic                              busy,
  input  logic [REQ_N-1:0]                  req_stb_i,
  output logic [REQ_N-1:0]                  req_ack_o,
  input  logic [BUNDLE_W(fml_depth)-1:0]    req0_data,
  input  logic [BUNDLE_W(fml_depth)-1:0]    req1_data,
  output logic                              blend_stb_o,
  input  logic                              blend_ack_i,
  output logic [BUNDLE_W(fml_depth)-1:0]    blend_data,
  input  logic                              blend_stb_i,
  output logic                              blend_ack_o,
  input  logic [fml_depth-2:0]              blend_dadr_f,
  input  logic [COLOR_W-1:0]                blend_color,
  output logic [REQ_N-1:0]                  res_stb_o,
  input  logic [REQ_N-1:0]                  res_ack_i,
  output logic [fml_depth-2:0]              res_dadr,
  output logic [COLOR_W-1:0]                res_color
);

  localparam int unsigned CW = $clog2(tag_depth) + 1;

  if (tag_depth < 8 || (tag_depth & (tag_depth - 1)) != 0) begin : g_bad_depth
    $error("tag_depth must be a power of two >= 8");
  end

  req_id_e          r_rr_last;
  logic [REQ_N-1:0] w_grant;
  logic             w_any_grant;
  logic             w_issue;
  logic             w_pop;
  logic             w_head;
  logic             w_empty;
  logic             w_full;
  logic [CW-1:0]    w_count;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    w_grant    = '0;
    w_grant[0] = req_stb_i[0] & (~req_stb_i[1] | (r_rr_last == REQ1));
    w_grant[1] = req_stb_i[1] & (~req_stb_i[0] | (r_rr_last == REQ0));
  end

  assign w_any_grant = |w_grant;
  assign blend_stb_o = w_any_grant & ~w_full;
  assign blend_data  = w_grant[1] ? req1_data : req0_data;
  assign req_ack_o   = w_grant & {REQ_N{blend_ack_i & ~w_full}};
  assign w_issue     = blend_stb_o & blend_ack_i;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)      r_rr_last <= REQ1;
    else if (w_issue) r_rr_last <= req_id_e'(w_grant[1]);
  end

  tmu2_tagfifo #(
    .DEPTH (tag_depth)
  ) u_tagfifo (
    .i_clk      (sys_clk),
    .i_rst      (sys_rst),
    .i_push     (w_issue),
    .i_push_tag (w_grant[1]),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_count    (w_count)
  );

  always_comb begin
    res_stb_o         = '0;
    res_stb_o[w_head] = blend_stb_i & ~w_empty;
  end

  assign blend_ack_o = res_ack_i[w_head] & ~w_empty;
  assign w_pop       = blend_stb_i & blend_ack_o;
  assign res_dadr    = blend_dadr_f;
  assign res_color   = blend_color;
  assign busy        = (w_count != '0) | (|req_stb_i);

  a_no_orphan_result: assert property (@(posedge sys_clk) disable iff (sys_rst)
    !(blend_stb_i && w_empty));

endmodule

// File: tb/tb_tmu2_blend_arb.sv
// Bench for tmu2_blend_arb: elastic 7-cycle blend model plus an expected-result queue.
module tb_tmu2_blend_arb;
  import tmu2_blend_arb_pkg::*;

  localparam int unsigned FD = 26;
  localparam int unsigned TD = 8;
  localparam int unsigned DW = FD - 1;
  localparam int unsigned BW = BUNDLE_W(FD);
  localparam int unsigned LAT = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [1:0]    req_stb_i, req_ack_o, res_stb_o, res_ack_i;
  logic [BW-1:0] req0_data, req1_data, blend_data;
  logic          blend_stb_o, blend_ack_i, blend_stb_i, blend_ack_o;
  logic [DW-1:0] blend_dadr_f, res_dadr;
  logic [15:0]   blend_color, res_color;

  always #5 clk = ~clk;

  tmu2_blend_arb #(.fml_depth(FD), .tag_depth(TD)) dut (
    .sys_clk(clk), .sys_rst(rst), .busy(busy),
    .req_stb_i(req_stb_i), .req_ack_o(req_ack_o),
    .req0_data(req0_data), .req1_data(req1_data),
    .blend_stb_o(blend_stb_o), .blend_ack_i(blend_ack_i), .blend_data(blend_data),
    .blend_stb_i(blend_stb_i), .blend_ack_o(blend_ack_o),
    .blend_dadr_f(blend_dadr_f), .blend_color(blend_color),
    .res_stb_o(res_stb_o), .res_ack_i(res_ack_i),
    .res_dadr(res_dadr), .res_color(res_color)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] blend_fn(input logic [BW-1:0] b);
    return b[COLORA_OFF +: 16] ^ b[COLORB_OFF +: 16] ^ b[COLORC_OFF +: 16]
         ^ b[COLORD_OFF +: 16] + {4'b0, b[XFRAC_OFF +: 6], b[YFRAC_OFF +: 6]};
  endfunction

  function automatic logic [BW-1:0] rand_bundle();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[BW-1:0];
  endfunction

  // Elastic blend model: accepts whenever stall_in is low, results appear LAT cycles later.
  typedef struct { logic [DW-1:0] d; logic [15:0] c; int unsigned rdy; } bent_t;
  bent_t       bq[$];
  int unsigned cyc;
  logic        stall_in;
  logic        b_v;
  logic [DW-1:0] b_d;
  logic [15:0] b_c;

  assign blend_ack_i  = ~stall_in;
  assign blend_stb_i  = b_v;
  assign blend_dadr_f = b_d;
  assign blend_color  = b_c;

  always @(posedge clk) begin
    if (rst) begin
      bq.delete();
      cyc = 0;
      b_v <= 1'b0;
    end else begin
      if (b_v && blend_ack_o) void'(bq.pop_front());
      if (blend_stb_o && blend_ack_i)
        bq.push_back('{blend_data[DADR_OFF +: DW], blend_fn(blend_data), cyc + LAT});
      cyc++;
      if (bq.size() != 0 && bq[0].rdy <= cyc) begin
        b_v <= 1'b1; b_d <= bq[0].d; b_c <= bq[0].c;
      end else begin
        b_v <= 1'b0;
      end
    end
  end

  // Requesters, reference arbiter state and scoreboard.
  typedef struct { logic tag; logic [DW-1:0] dadr; logic [15:0] col; } sb_t;
  sb_t           sb[$];
  logic [BW-1:0] rq0[$], rq1[$];
  logic          ack_log[$], res_log[$];
  logic [1:0]    en, res_ack;
  logic          m_rr;
  int            m_count;
  int unsigned   n_issue, n_res0, n_res1;

  task automatic drive_inputs();
    req_stb_i[0] = en[0] && rq0.size() != 0;
    req_stb_i[1] = en[1] && rq1.size() != 0;
    req0_data    = rq0.size() != 0 ? rq0[0] : '0;
    req1_data    = rq1.size() != 0 ? rq1[0] : '0;
    res_ack_i    = res_ack;
  endtask

  task automatic tick();
    logic [1:0] g, exp_rs;
    logic full, exp_stb, issue, pop, have, head;
    logic [BW-1:0] d;
    @(negedge clk);
    full    = (m_count == TD);
    g[0]    = req_stb_i[0] & (~req_stb_i[1] | m_rr);
    g[1]    = req_stb_i[1] & (~req_stb_i[0] | ~m_rr);
    exp_stb = (|g) & ~full;
    d       = g[1] ? req1_data : req0_data;
    chk("blend_stb", blend_stb_o, exp_stb);
    chk("req_ack", req_ack_o, g & {2{blend_ack_i & ~full}});
    chk("blend_data", blend_data, d);
    have   = sb.size() != 0;
    head   = have ? sb[0].tag : 1'b0;
    exp_rs = (blend_stb_i && have) ? (head ? 2'b10 : 2'b01) : 2'b00;
    chk("res_stb", res_stb_o, exp_rs);
    chk("blend_ack_o", blend_ack_o, have & res_ack_i[head]);
    if (exp_rs != 2'b00) begin
      chk("res_dadr", res_dadr, sb[0].dadr);
      chk("res_color", res_color, sb[0].col);
    end
    chk("busy", busy, (m_count != 0) || (req_stb_i != 2'b00));
    issue = exp_stb & blend_ack_i;
    pop   = blend_stb_i & have & res_ack_i[head];
    if (pop) begin
      res_log.push_back(head);
      if (head) n_res1++; else n_res0++;
      void'(sb.pop_front());
      m_count--;
    end
    if (issue) begin
      ack_log.push_back(g[1]);
      sb.push_back('{g[1], d[DADR_OFF +: DW], blend_fn(d)});
      m_rr = g[1];
      if (g[1]) void'(rq1.pop_front()); else void'(rq0.pop_front());
      n_issue++;
      m_count++;
    end
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic run_until_idle(input string tag, input int unsigned max_cyc);
    int unsigned i;
    for (i = 0; i < max_cyc; i++) begin
      if (sb.size() == 0 && (rq0.size() == 0 || !en[0]) && (rq1.size() == 0 || !en[1])) break;
      tick();
    end
    chk(tag, i < max_cyc, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_count = 0;
    m_rr    = 1'b1;
    sb.delete();
    drive_inputs();
  endtask

  task automatic fill(input int unsigned r, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      if (r == 0) rq0.push_back(rand_bundle()); else rq1.push_back(rand_bundle());
    end
  endtask

  initial begin
    int unsigned base, cnt;
    rst = 1'b1; en = 2'b00; res_ack = 2'b11; stall_in = 1'b0;
    n_issue = 0; n_res0 = 0; n_res1 = 0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("rst_blend_stb", blend_stb_o, 1'b0);
    chk("rst_req_ack", req_ack_o, 2'b00);
    chk("rst_res_stb", res_stb_o, 2'b00);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;

    // Contention from reset: grants must alternate starting with requester 0.
    ack_log.delete(); res_log.delete();
    fill(0, 3); fill(1, 3); en = 2'b11; drive_inputs();
    run_until_idle("contend_drain", 200);
    chk("contend_n_ack", ack_log.size(), 6);
    chk("contend_n_res", res_log.size(), 6);
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < ack_log.size()) chk("contend_grant", ack_log[i], i[0]);
      if (i < res_log.size()) chk("contend_res_tag", res_log[i], i[0]);
    end

    // Single requester.
    base = n_res0; cnt = n_res1;
    fill(0, 3); en = 2'b01; drive_inputs();
    run_until_idle("single_drain", 200);
    chk("single_res0", n_res0 - base, 3);
    chk("single_res1", n_res1 - cnt, 0);
    tick();
    chk("single_busy", busy, 1'b0);

    // Full: results blocked, exactly tag_depth issues.
    base = n_issue;
    res_ack = 2'b00; fill(0, 10); drive_inputs();
    repeat (30) tick();
    chk("full_issues", n_issue - base, TD);
    @(negedge clk);
    chk("full_req_ack", req_ack_o, 2'b00);
    chk("full_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    base = n_res0;
    res_ack = 2'b11; drive_inputs();
    run_until_idle("full_drain", 300);
    chk("full_res0", n_res0 - base, 10);

    // Steady state: one op per cycle with in-flight count constant.
    fill(0, 40); fill(1, 40); en = 2'b11; drive_inputs();
    repeat (15) tick();
    base = n_issue; cnt = sb.size();
    repeat (20) tick();
    chk("steady_issues", n_issue - base, 20);
    chk("steady_inflight", sb.size(), cnt);
    run_until_idle("steady_drain", 400);

    // Lane back-pressure: a tag-1 result at the head holds later lane-0 results.
    res_log.delete();
    res_ack = 2'b01; fill(1, 1); en = 2'b10; drive_inputs();
    tick();
    fill(0, 3); en = 2'b11; drive_inputs();
    base = n_res0;
    repeat (20) tick();
    chk("lane_held", sb.size(), 4);
    chk("lane_res0", n_res0 - base, 0);
    @(negedge clk);
    chk("lane_blend_ack", blend_ack_o, 1'b0);
    chk("lane_res_stb", res_stb_o, 2'b10);
    @(posedge clk);
    #1;
    res_ack = 2'b11; drive_inputs();
    run_until_idle("lane_drain", 200);
    chk("lane_n_res", res_log.size(), 4);
    for (int unsigned i = 0; i < 4; i++)
      if (i < res_log.size()) chk("lane_order", res_log[i], i == 0);

    // Reset with 5 in flight.
    res_ack = 2'b00; fill(0, 5); en = 2'b01; drive_inputs();
    repeat (5) tick();
    chk("rst_inflight", sb.size(), 5);
    do_reset();
    @(negedge clk);
    chk("rst2_res_stb", res_stb_o, 2'b00);
    chk("rst2_busy", busy, req_stb_i != 2'b00);
    @(posedge clk);
    #1;
    res_ack = 2'b11; ack_log.delete();
    fill(0, 2); fill(1, 2); en = 2'b11; drive_inputs();
    run_until_idle("rst2_drain", 200);
    if (ack_log.size() != 0) chk("rst2_first_grant", ack_log[0], 1'b0);
    else chk("rst2_first_grant", 1'b1, 1'b0);

    // Random traffic with blend stalls and per-lane result back-pressure.
    for (int unsigned i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) fill($urandom_range(0, 1), 1);
      stall_in = ($urandom_range(0, 3) == 0);
      res_ack  = 2'($urandom_range(0, 3));
      drive_inputs();
      tick();
    end
    stall_in = 1'b0; res_ack = 2'b11; drive_inputs();
    run_until_idle("rand_drain", 1000);
    chk("rand_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
